// File: rtl/mul_seq_ctrl.sv
// Sequential radix-2 Booth multiplier controller: one Booth step per clock, 64-bit HI/LO result plus flags.
// Optional MUL_SEQ_ZERO_BYPASS_EN: a zero operand skips RUN and finishes in the start cycle.
module mul_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, q1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH:0]   m_ext, sum, a_step;
  logic [WIDTH-1:0] q_step;
  logic             last_step, zero_op;

`ifdef MUL_SEQ_ZERO_BYPASS_EN
  assign zero_op = (in1 == '0) || (in2 == '0);
`else
  assign zero_op = 1'b0;
`endif

  function automatic logic [3:0] result_flags(input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] l);
    return {h[WIDTH-1], ({h, l} == '0), 1'b0, (h != {WIDTH{l[WIDTH-1]}})};
  endfunction

  // A carries one guard bit so that subtracting -2^(WIDTH-1) cannot wrap.
  assign m_ext     = {m_q[WIDTH-1], m_q};
  assign last_step = (state_q == RUN) && (cnt_q == LAST);

  always_comb begin
    sum = a_q;
    case ({q_q[0], q1_q})
      2'b01:   sum = a_q + m_ext;
      2'b10:   sum = a_q - m_ext;
      default: sum = a_q;
    endcase
    a_step = {sum[WIDTH], sum[WIDTH:1]};
    q_step = {sum[0], q_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = zero_op ? DONE : RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d   = in1;
          a_d   = '0;
          q_d   = in2;
          q1_d  = 1'b0;
          cnt_d = '0;
          if (zero_op) begin
            hi_d    = '0;
            lo_d    = '0;
            flags_d = 4'b0100;
          end
        end
      end
      RUN: begin
        a_d   = a_step;
        q_d   = q_step;
        q1_d  = q_q[0];
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          hi_d    = a_step[WIDTH-1:0];
          lo_d    = q_step;
          flags_d = result_flags(a_step[WIDTH-1:0], q_step);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      flags_q <= '0;
    end else begin
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      flags_q <= flags_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: cycle-level reference built on a plain 64-bit signed product, plus literal cases.
// Honours MUL_SEQ_ZERO_BYPASS_EN for the zero-operand latency.
module tb_mul_seq_ctrl;

  localparam int W = 32;
`ifdef MUL_SEQ_ZERO_BYPASS_EN
  localparam int ZLAT = 0;
  localparam bit BYPASS = 1'b1;
`else
  localparam int ZLAT = W;
  localparam bit BYPASS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clr, start;
  logic [W-1:0] in1, in2;
  logic [W-1:0] hi, lo;
  logic [3:0]   flags;
  logic         busy, done;

  int pass_cnt = 0;
  int total_cnt = 0;

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .in1(in1), .in2(in2),
    .hi(hi), .lo(lo), .flags(flags), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference: phase 0 idle, 1 computing (e edges since start), 2 done cycle.
  int          m_phase = 0;
  int          m_e = 0;
  logic [63:0] m_prod = '0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [3:0]  m_flags = '0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  int          done_seen = 0;

  function automatic logic [3:0] ref_flags(input logic [63:0] p);
    longint lo_sext;
    lo_sext = longint'($signed(p[31:0]));
    return {p[63], (p == 64'd0), 1'b0, (longint'(p) != lo_sext)};
  endfunction

  initial begin
    longint sa, sb;
    forever begin
      @(posedge clk);
      if (clr) begin
        m_phase = 0; m_hi = '0; m_lo = '0; m_flags = '0; m_busy = 0; m_done = 0;
      end else begin
        case (m_phase)
          0: if (start) begin
            sa = longint'($signed(in1));
            sb = longint'($signed(in2));
            m_prod = 64'(sa * sb);
            if (BYPASS && (in1 == '0 || in2 == '0)) begin
              m_hi = '0; m_lo = '0; m_flags = 4'b0100; m_done = 1; m_phase = 2;
            end else begin
              m_e = 0; m_busy = 1; m_phase = 1;
            end
          end
          1: begin
            m_e++;
            if (m_e == W) begin
              m_hi = m_prod[63:32]; m_lo = m_prod[31:0]; m_flags = ref_flags(m_prod);
              m_busy = 0; m_done = 1; m_phase = 2;
            end
          end
          default: begin
            m_done = 0; m_phase = 0;
          end
        endcase
      end
      #1;
      if (done) done_seen++;
      chk("cyc_hilo", {hi, lo}, {m_hi, m_lo});
      chk("cyc_ctl", {58'd0, flags, busy, done}, {58'd0, m_flags, m_busy, m_done});
      chk("cyc_excl", {63'd0, busy & done}, 64'd0);
    end
  end

  task automatic wait_idle();
    @(negedge clk);
    while (busy || done) @(negedge clk);
  endtask

  task automatic wait_done(inout int lat);
    while (!done && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] eh,
                       input logic [W-1:0] el, input logic [3:0] ef, input int elat, input string nm);
    int lat;
    wait_idle();
    in1 = a; in2 = b; start = 1;
    @(posedge clk); #1; lat = 0;
    #1; start = 0; in1 = $urandom; in2 = $urandom;
    wait_done(lat);
    chk({nm, "_lat"}, 64'(lat), 64'(elat));
    chk({nm, "_hilo"}, {hi, lo}, {eh, el});
    chk({nm, "_flags"}, 64'(flags), 64'(ef));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15)) - 32'd8;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, d0;
    clr = 1; start = 0; in1 = '0; in2 = '0;
    repeat (2) @(negedge clk);
    clr = 0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("rst_hilo", {hi, lo}, 64'd0);
      chk("rst_ctl", {58'd0, flags, busy, done}, 64'd0);
    end

    do_op(32'd6, 32'd7, 32'h0, 32'h2A, 4'b0000, W, "op_6x7");
    repeat (10) begin
      @(posedge clk); #1;
      chk("hold_hilo", {hi, lo}, {32'h0, 32'h2A});
    end
    do_op(-32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 4'b1000, W, "op_m3x5");
    do_op(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 4'b0001, W, "op_min2");
    do_op(32'h0, 32'h1234, 32'h0, 32'h0, 4'b0100, ZLAT, "op_zero");

    // A second start mid-operation must be dropped.
    wait_idle();
    in1 = 32'd6; in2 = 32'd7; start = 1;
    @(posedge clk); #1; lat = 0;
    #1; start = 0;
    repeat (9) begin @(posedge clk); #1; lat++; end
    #1; in1 = 32'd2; in2 = 32'd2; start = 1;
    @(posedge clk); #1; lat++;
    #1; start = 0;
    wait_done(lat);
    chk("ign_lat", 64'(lat), 64'(W));
    chk("ign_hilo", {hi, lo}, {32'h0, 32'h2A});
    repeat (3) @(posedge clk);
    #1; chk("ign_nodone", {63'd0, done | busy}, 64'd0);

    // Abort with clr mid-run.
    do_op(32'd3, 32'd3, 32'h0, 32'h9, 4'b0000, W, "op_3x3");
    wait_idle();
    in1 = 32'd6; in2 = 32'd7; start = 1;
    @(posedge clk); #1;
    #1; start = 0;
    repeat (14) @(posedge clk);
    @(negedge clk); clr = 1;
    @(posedge clk); #1;
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_ctl", {58'd0, flags, busy, done}, 64'd0);
    @(negedge clk); clr = 0;
    d0 = done_seen;
    repeat (40) @(posedge clk);
    #1; chk("abort_nodone", 64'(done_seen - d0), 64'd0);
    do_op(-32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 4'b1000, W, "abort_next");

    d0 = done_seen;
    repeat (1500) begin
      @(negedge clk);
      clr   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 2) == 0);
      in1   = pick();
      in2   = pick();
    end
    @(negedge clk); clr = 0; start = 0;
    repeat (40) @(posedge clk);
    #1; chk("rand_ops", {63'd0, (done_seen - d0) > 10}, 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
